bp_be_loop_inference_sched: RTL and testbench
=============================================

Name: bp_be_loop_inference_sched

Overview:
- Scheduler that shares the single backend loop-inference unit between num_req_p striding-load requesters (stride-table entries).
- Round-robin grants one requester and drives the unit's start/confirm/striding-pc inputs.
- Accepts the unit's iteration estimate and returns it to the owning requester over a valid/ready response channel.
- Aborts unconfirmed searches by timeout; sits between the stride detector and the loop-inference unit in bp_be_checker.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies vaddr_width_p.
- num_req_p, 4, number of requesters (>=2).
- timeout_p, 1024, max cycles in unconfirmed search before abort (>=2).
- iter_width_p, 8, width of the iteration estimate; matches the inference-unit output.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- req_v_i  in  num_req_p  per-requester discovery request.
- req_pc_i  in  num_req_p*vaddr_width_p  per-requester striding-load PC; slot i is bits [i*vaddr_width_p +: vaddr_width_p].
- req_confirm_i  in  num_req_p  per-requester confirm (stride verified).
- req_yumi_o  out  num_req_p  one-hot accept of the granted request.
- start_discovery_o  out  1  to unit: start discovery.
- confirm_discovery_o  out  1  to unit: confirm discovery.
- striding_pc_o  out  vaddr_width_p  to unit: striding PC.
- li_iters_i  in  iter_width_p  from unit: remaining iterations.
- li_v_i  in  1  from unit: result valid.
- li_yumi_o  out  1  to unit: result consumed.
- resp_v_o  out  1  response valid.
- resp_id_o  out  `BSG_SAFE_CLOG2(num_req_p)  owning requester index.
- resp_iters_o  out  iter_width_p  iteration estimate; 0 on timeout.
- resp_timeout_o  out  1  search aborted by timeout.
- resp_ready_i  in  1  response accepted.
- busy_o  out  1  state != e_ls_idle.

Behaviour:
- Reset (async assert, sync deassert): state=e_ls_idle; rr pointer=0; owner, striding_pc_r, timer, confirmed_r, and response registers all 0. All outputs 0.
- e_ls_idle:
  - If |req_v_i, grant the first set bit at or after rr_ptr, wrapping.
  - req_yumi_o one-hot asserts combinationally in the same cycle.
  - Latch owner and pc; rr_ptr <= owner+1, wrapping at num_req_p; go to e_ls_start.
  - No grant in any other state.
- e_ls_start (1 cycle):
  - start_discovery_o=1, striding_pc_o=striding_pc_r; timer<=0, confirmed_r<=0; go to e_ls_search.
- striding_pc_o is held at striding_pc_r in every non-idle state; it is 0 in idle.
- e_ls_search:
  - When req_confirm_i[owner]=1: confirm_discovery_o=1 for exactly one cycle; confirmed_r<=1; timer frozen.
  - Confirms from non-owners are ignored. Repeated owner confirms do not re-pulse.
  - While unconfirmed, timer increments each cycle.
  - When timer==timeout_p-1 and no confirm this cycle: load response (iters=0, timeout=1); go to e_ls_resp.
  - Confirm and timeout in the same cycle: confirm wins.
  - li_yumi_o = li_v_i & confirmed_r. On that handshake: resp_iters<=li_iters_i, timeout=0; go to e_ls_resp.
  - li_v_i while unconfirmed is not consumed; li_yumi_o=0.
- e_ls_resp:
  - resp_v_o=1 with resp_id_o/iters/timeout held stable until resp_ready_i=1; then go to e_ls_idle.
  - resp_ready_i outside e_ls_resp is ignored.
- A timed-out unit needs no abort: the next start_discovery_o re-arms it because it is unconfirmed.
- Latency: request grant to start_discovery_o is 1 cycle. li_v_i handshake to resp_v_o is 1 cycle.
- Requester dropping req_v_i after grant has no effect.
- Async reset mid-operation returns to idle immediately; the unit is reset by the same system reset.

Optional Feature:
- BP_BE_LOOP_SCHED_STATS_EN.
- Defined: adds outputs stat_done_o and stat_timeout_o, 16 bits each, saturating.
  - stat_done_o increments on each non-timeout response handshake.
  - stat_timeout_o increments on each timeout response handshake.
  - Both reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- bp_be_pkg: enum bp_be_loop_sched_state_e {e_ls_idle, e_ls_start, e_ls_search, e_ls_resp} (2 bits).
- bp_be_pkg: struct bp_be_loop_sched_resp_s {id, iters, timeout}.
- Sub-module: bsg_arb_round_robin for the grant; the FSM supplies the yumi.

Test Plan:
- Single request: req_v_i=4'b0100, pc=0x8000_1000 -> req_yumi_o=4'b0100 same cycle; start_discovery_o next cycle with striding_pc_o=0x8000_1000; confirm on req 2 -> one confirm_discovery_o pulse; li_v_i with iters=37 -> li_yumi_o=1, then resp_v_o with id=2, iters=37, timeout=0.
- Round-robin: req_v_i=4'b1111 held across four completions -> grants in order 0,1,2,3, then 0.
- Timeout: timeout_p=16, grant, no confirm -> resp_v_o with timeout=1, iters=0 exactly 16 cycles after entering e_ls_search.
- Confirm on the timeout cycle -> no timeout; a later li_v_i result is delivered normally. Confirm from a non-owner -> ignored, timeout still fires.
- Backpressure: resp_ready_i=0 for 5 cycles -> resp fields stable, no new grant; ready=1 -> idle next cycle.
- Reset: assert reset_n_i=0 in e_ls_search -> all outputs 0 immediately; after release, a pending request is granted in the next cycle.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Shared types for the backend loop-inference scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bp_be_pkg;

    // Defaults the scheduler is built with; the response struct is sized from these,
    // so num_req_p / iter_width_p overrides must be mirrored here.
    localparam int bp_be_ls_num_req_gp    = 4;
    localparam int bp_be_ls_id_width_gp   = (bp_be_ls_num_req_gp > 1) ? $clog2(bp_be_ls_num_req_gp) : 1;
    localparam int bp_be_ls_iter_width_gp = 8;

    typedef enum logic [1:0] {
        e_ls_idle   = 2'd0,
        e_ls_start  = 2'd1,
        e_ls_search = 2'd2,
        e_ls_resp   = 2'd3
    } bp_be_loop_sched_state_e;

    typedef struct packed {
        logic [bp_be_ls_id_width_gp-1:0]   id;
        logic [bp_be_ls_iter_width_gp-1:0] iters;
        logic                              timeout;
    } bp_be_loop_sched_resp_s;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: grants the first request at or after the rotating pointer.
// Latency: grant is combinational; the pointer moves on the cycle yumi_i is seen.
// Backpressure: without yumi_i the pointer holds and the same grant is re-offered.
module bsg_arb_round_robin #(
    parameter  int width_p      = 4,
    localparam int tag_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [width_p-1:0]      reqs_i,
    output logic [width_p-1:0]      grants_o,
    output logic [tag_width_lp-1:0] tag_o,
    output logic                    v_o,
    input  logic                    yumi_i
);

    logic [tag_width_lp-1:0] ptr_q, ptr_d;

    // Scan from the pointer upward with wrap and take the first requester found.
    always_comb begin
        int                      idx;
        logic [tag_width_lp-1:0] cand;
        grants_o = '0;
        tag_o    = '0;
        v_o      = 1'b0;
        idx      = 0;
        cand     = '0;
        for (int i = 0; i < width_p; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= width_p) idx = idx - width_p;
            cand = tag_width_lp'(idx);
            if (!v_o && reqs_i[cand]) begin
                v_o            = 1'b1;
                tag_o          = cand;
                grants_o[cand] = 1'b1;
            end
        end
    end

    // Next search starts just past the winner so it yields to everyone else first.
    always_comb begin
        ptr_d = ptr_q;
        if (yumi_i && v_o) begin
            ptr_d = (tag_o == tag_width_lp'(width_p - 1)) ? '0 : tag_o + tag_width_lp'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) ptr_q <= '0;
        else            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bp_be_loop_inference_sched.sv
// Shares one loop-inference unit among striding-load requesters; optional stats via BP_BE_LOOP_SCHED_STATS_EN.
// Latency: grant->start_discovery 1 cycle; li_v handshake->resp_v 1 cycle; unconfirmed search aborts after timeout_p cycles.
// Backpressure: resp held until resp_ready_i; no new grant until then; unit result consumed only once confirmed.
module bp_be_loop_inference_sched
    import bp_be_pkg::*;
#(
    parameter  int vaddr_width_p  = 39,
    parameter  int num_req_p      = bp_be_ls_num_req_gp,
    parameter  int timeout_p      = 1024,
    parameter  int iter_width_p   = bp_be_ls_iter_width_gp,
    localparam int id_width_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    localparam int timer_width_lp = $clog2(timeout_p)
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_req_p-1:0]               req_v_i,
    input  logic [num_req_p*vaddr_width_p-1:0] req_pc_i,
    input  logic [num_req_p-1:0]               req_confirm_i,
    output logic [num_req_p-1:0]               req_yumi_o,
    output logic                               start_discovery_o,
    output logic                               confirm_discovery_o,
    output logic [vaddr_width_p-1:0]           striding_pc_o,
    input  logic [iter_width_p-1:0]            li_iters_i,
    input  logic                               li_v_i,
    output logic                               li_yumi_o,
    output logic                               resp_v_o,
    output logic [id_width_lp-1:0]             resp_id_o,
    output logic [iter_width_p-1:0]            resp_iters_o,
    output logic                               resp_timeout_o,
    input  logic                               resp_ready_i,
    output logic                               busy_o
`ifdef BP_BE_LOOP_SCHED_STATS_EN
   ,output logic [15:0]                        stat_done_o
   ,output logic [15:0]                        stat_timeout_o
`endif
);

    bp_be_loop_sched_state_e state_q, state_d;
    logic [id_width_lp-1:0]    owner_q, owner_d;
    logic [vaddr_width_p-1:0]  striding_pc_q, striding_pc_d;
    logic [timer_width_lp-1:0] timer_q, timer_d;
    logic                      confirmed_q, confirmed_d;
    bp_be_loop_sched_resp_s    resp_q, resp_d;

    logic [num_req_p-1:0]      arb_grants;
    logic [id_width_lp-1:0]    arb_tag;
    logic                      arb_v;
    logic                      grant_fire;
    logic                      owner_confirm;
    logic [vaddr_width_p-1:0]  req_pc_arr [num_req_p];

    // Grants are offered only while idle; reset_n_i gating keeps req_yumi_o low during reset.
    assign grant_fire = reset_n_i && (state_q == e_ls_idle) && arb_v;
    assign req_yumi_o = grant_fire ? arb_grants : '0;

    bsg_arb_round_robin #(.width_p(num_req_p)) u_arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .reqs_i    (req_v_i),
        .grants_o  (arb_grants),
        .tag_o     (arb_tag),
        .v_o       (arb_v),
        .yumi_i    (grant_fire)
    );

    // Unpack the flat per-requester PC bus into slots.
    always_comb begin
        for (int i = 0; i < num_req_p; i++) begin
            req_pc_arr[i] = req_pc_i[i*vaddr_width_p +: vaddr_width_p];
        end
    end

    // FSM next-state and unit handshakes.
    always_comb begin
        state_d             = state_q;
        owner_d             = owner_q;
        striding_pc_d       = striding_pc_q;
        timer_d             = timer_q;
        confirmed_d         = confirmed_q;
        resp_d              = resp_q;
        start_discovery_o   = 1'b0;
        confirm_discovery_o = 1'b0;
        li_yumi_o           = 1'b0;
        owner_confirm       = req_confirm_i[owner_q];

        case (state_q)
            e_ls_idle: begin
                if (grant_fire) begin
                    owner_d       = arb_tag;
                    striding_pc_d = req_pc_arr[arb_tag];
                    state_d       = e_ls_start;
                end
            end
            e_ls_start: begin
                start_discovery_o = 1'b1;
                timer_d           = '0;
                confirmed_d       = 1'b0;
                state_d           = e_ls_search;
            end
            e_ls_search: begin
                if (!confirmed_q) begin
                    // A confirm arriving on the last timer cycle still wins over the abort.
                    if (owner_confirm) begin
                        confirm_discovery_o = 1'b1;
                        confirmed_d         = 1'b1;
                    end else if (timer_q == timer_width_lp'(timeout_p - 1)) begin
                        resp_d.id      = owner_q;
                        resp_d.iters   = '0;
                        resp_d.timeout = 1'b1;
                        state_d        = e_ls_resp;
                    end else begin
                        timer_d = timer_q + timer_width_lp'(1);
                    end
                end else if (li_v_i) begin
                    li_yumi_o      = 1'b1;
                    resp_d.id      = owner_q;
                    resp_d.iters   = li_iters_i;
                    resp_d.timeout = 1'b0;
                    state_d        = e_ls_resp;
                end
            end
            e_ls_resp: begin
                if (resp_ready_i) state_d = e_ls_idle;
            end
            default: state_d = e_ls_idle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= e_ls_idle;
            owner_q       <= '0;
            striding_pc_q <= '0;
            timer_q       <= '0;
            confirmed_q   <= 1'b0;
            resp_q        <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            striding_pc_q <= striding_pc_d;
            timer_q       <= timer_d;
            confirmed_q   <= confirmed_d;
            resp_q        <= resp_d;
        end
    end

    assign striding_pc_o  = (state_q != e_ls_idle) ? striding_pc_q : '0;
    assign busy_o         = (state_q != e_ls_idle);
    assign resp_v_o       = (state_q == e_ls_resp);
    assign resp_id_o      = resp_q.id;
    assign resp_iters_o   = resp_q.iters;
    assign resp_timeout_o = resp_q.timeout;

`ifdef BP_BE_LOOP_SCHED_STATS_EN
    logic [15:0] stat_done_q, stat_done_d;
    logic [15:0] stat_timeout_q, stat_timeout_d;

    // Saturating outcome counters, bumped on each response handshake.
    always_comb begin
        stat_done_d    = stat_done_q;
        stat_timeout_d = stat_timeout_q;
        if (resp_v_o && resp_ready_i) begin
            if (resp_q.timeout) begin
                if (stat_timeout_q != 16'hffff) stat_timeout_d = stat_timeout_q + 16'd1;
            end else begin
                if (stat_done_q != 16'hffff) stat_done_d = stat_done_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stat_done_q    <= '0;
            stat_timeout_q <= '0;
        end else begin
            stat_done_q    <= stat_done_d;
            stat_timeout_q <= stat_timeout_d;
        end
    end

    assign stat_done_o    = stat_done_q;
    assign stat_timeout_o = stat_timeout_q;
`endif

endmodule

// File: tb/tb_bp_be_loop_inference_sched.sv
// Self-checking bench for the loop-inference scheduler.
// Latency: drives inputs 1ns after the rising edge, samples 1ns later.
// Backpressure: exercises held responses and ignored ready outside the response phase.
`timescale 1ns/1ps
module tb_bp_be_loop_inference_sched;

    localparam int VA = 39;
    localparam int NR = 4;
    localparam int TO = 16;
    localparam int IW = 8;

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic [NR-1:0]   req_v_i;
    logic [NR*VA-1:0] req_pc_i;
    logic [NR-1:0]   req_confirm_i;
    logic [NR-1:0]   req_yumi_o;
    logic            start_discovery_o;
    logic            confirm_discovery_o;
    logic [VA-1:0]   striding_pc_o;
    logic [IW-1:0]   li_iters_i;
    logic            li_v_i;
    logic            li_yumi_o;
    logic            resp_v_o;
    logic [1:0]      resp_id_o;
    logic [IW-1:0]   resp_iters_o;
    logic            resp_timeout_o;
    logic            resp_ready_i;
    logic            busy_o;

    always #5 clk_i = ~clk_i;

    bp_be_loop_inference_sched #(
        .vaddr_width_p (VA),
        .num_req_p     (NR),
        .timeout_p     (TO),
        .iter_width_p  (IW)
    ) dut (
        .clk_i               (clk_i),
        .reset_n_i           (reset_n_i),
        .req_v_i             (req_v_i),
        .req_pc_i            (req_pc_i),
        .req_confirm_i       (req_confirm_i),
        .req_yumi_o          (req_yumi_o),
        .start_discovery_o   (start_discovery_o),
        .confirm_discovery_o (confirm_discovery_o),
        .striding_pc_o       (striding_pc_o),
        .li_iters_i          (li_iters_i),
        .li_v_i              (li_v_i),
        .li_yumi_o           (li_yumi_o),
        .resp_v_o            (resp_v_o),
        .resp_id_o           (resp_id_o),
        .resp_iters_o        (resp_iters_o),
        .resp_timeout_o      (resp_timeout_o),
        .resp_ready_i        (resp_ready_i),
        .busy_o              (busy_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Slot 2 carries 0x8000_1000; neighbours are spaced 0x40 apart.
    function automatic logic [VA-1:0] pc_of(input int i);
        logic [VA-1:0] base;
        base = 39'h0_8000_0f80;
        return base + VA'(i * 64);
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({req_yumi_o, start_discovery_o, confirm_discovery_o, striding_pc_o, li_yumi_o,
                    resp_v_o, resp_id_o, resp_iters_o, resp_timeout_o, busy_o});
    endfunction

    // One complete, confirmed transaction from idle back to idle.
    task automatic run_txn(input logic [NR-1:0] rv, input logic [IW-1:0] it,
                           input logic [NR-1:0] ey, input int eid);
        logic [NR-1:0] oh;
        oh = NR'(1) << eid;
        req_v_i = rv; #1;
        chk("vec_grant_yumi", req_yumi_o, ey);
        chk("vec_idle_not_busy", busy_o, 0);
        tick(); req_v_i = '0; #1;
        chk("vec_start_pulse", start_discovery_o, 1);
        chk("vec_start_pc", striding_pc_o, pc_of(eid));
        tick(); li_v_i = 1'b1; li_iters_i = it; #1;
        chk("vec_li_unconfirmed", li_yumi_o, 0);
        tick(); req_confirm_i = oh; #1;
        chk("vec_confirm_pulse", confirm_discovery_o, 1);
        tick(); #1;
        chk("vec_confirm_once", confirm_discovery_o, 0);
        chk("vec_li_yumi", li_yumi_o, 1);
        tick(); li_v_i = 1'b0; req_confirm_i = '0; #1;
        chk("vec_resp_v", resp_v_o, 1);
        chk("vec_resp_id", resp_id_o, eid);
        chk("vec_resp_iters", resp_iters_o, it);
        chk("vec_resp_timeout", resp_timeout_o, 0);
        resp_ready_i = 1'b1; tick(); resp_ready_i = 1'b0; #1;
        chk("vec_back_idle", busy_o, 0);
    endtask

    typedef struct {
        logic [NR-1:0] req_v;
        logic [IW-1:0] iters;
        logic [NR-1:0] exp_yumi;
        int            exp_id;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            bad;
        int            rr_m;
        int            own;
        int            conf_at;
        int            li_at;
        int            end_cyc;
        int            rdy_wait;
        bit            to;
        logic [NR-1:0] mask;
        logic [NR-1:0] oh;
        logic [IW-1:0] it;

        // Round-robin order from a fresh pointer, then sparse masks exercising wrap.
        vecs[0] = '{4'b1111, 8'd11,  4'b0001, 0};
        vecs[1] = '{4'b1111, 8'd22,  4'b0010, 1};
        vecs[2] = '{4'b1111, 8'd33,  4'b0100, 2};
        vecs[3] = '{4'b1111, 8'd44,  4'b1000, 3};
        vecs[4] = '{4'b1111, 8'd55,  4'b0001, 0};
        vecs[5] = '{4'b0100, 8'd37,  4'b0100, 2};
        vecs[6] = '{4'b1001, 8'd200, 4'b1000, 3};
        vecs[7] = '{4'b0110, 8'd0,   4'b0010, 1};
        vecs[8] = '{4'b0001, 8'd255, 4'b0001, 0};
        vecs[9] = '{4'b1010, 8'd128, 4'b0010, 1};

        for (int i = 0; i < NR; i++) req_pc_i[i*VA +: VA] = pc_of(i);
        reset_n_i     = 1'b0;
        req_v_i       = 4'b1111;
        req_confirm_i = 4'b1111;
        li_v_i        = 1'b1;
        li_iters_i    = 8'h5a;
        resp_ready_i  = 1'b1;
        #1;
        chk("reset_outputs_zero", all_outs(), 0);
        tick(); tick();
        reset_n_i = 1'b1; req_v_i = '0; req_confirm_i = '0; li_v_i = 1'b0; resp_ready_i = 1'b0; #1;
        chk("post_reset_idle", all_outs(), 0);

        for (int v = 0; v < 10; v++) begin
            run_txn(vecs[v].req_v, vecs[v].iters, vecs[v].exp_yumi, vecs[v].exp_id);
        end

        // Timeout with only non-owner confirms; resp appears 16 cycles after entering search.
        req_v_i = 4'b0001; #1;
        chk("to_grant", req_yumi_o, 4'b0001);
        tick(); req_v_i = '0; tick();
        req_confirm_i = 4'b1110; li_v_i = 1'b1; li_iters_i = 8'haa;
        bad = 0;
        for (int k = 0; k < TO; k++) begin
            #1;
            if (resp_v_o || confirm_discovery_o || li_yumi_o || !busy_o) bad++;
            tick();
        end
        chk("to_quiet_during_search", bad, 0);
        req_confirm_i = '0; li_v_i = 1'b0; #1;
        chk("to_resp_v", resp_v_o, 1);
        chk("to_resp_timeout", resp_timeout_o, 1);
        chk("to_resp_iters", resp_iters_o, 0);
        chk("to_resp_id", resp_id_o, 0);

        // Backpressure: held response, no grant while requests pend.
        req_v_i = 4'b1111; bad = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (!resp_v_o || resp_id_o != 0 || resp_iters_o != 0 || !resp_timeout_o || req_yumi_o != 0) bad++;
            tick();
        end
        chk("bp_resp_stable", bad, 0);
        resp_ready_i = 1'b1; tick(); resp_ready_i = 1'b0; #1;
        chk("bp_idle_after_ready", {resp_v_o, busy_o}, 0);
        chk("bp_next_grant", req_yumi_o, 4'b0010);

        // Confirm lands on the last timer cycle: confirm wins, result delivered later.
        tick(); req_v_i = '0; tick();
        for (int k = 0; k < TO - 1; k++) tick();
        req_confirm_i = 4'b0010; #1;
        chk("ct_confirm_pulse", confirm_discovery_o, 1);
        chk("ct_no_resp_yet", resp_v_o, 0);
        tick(); req_confirm_i = '0; #1;
        chk("ct_no_timeout", {resp_v_o, busy_o}, 2'b01);
        tick(); tick(); tick();
        li_v_i = 1'b1; li_iters_i = 8'h5a; #1;
        chk("ct_li_yumi", li_yumi_o, 1);
        tick(); li_v_i = 1'b0; #1;
        chk("ct_resp", {resp_v_o, resp_timeout_o, resp_iters_o, 6'(resp_id_o)}, {1'b1, 1'b0, 8'h5a, 6'd1});
        resp_ready_i = 1'b1; tick(); resp_ready_i = 1'b0;

        // Reset mid-search with a pending request.
        req_v_i = 4'b0100; #1;
        chk("rs_grant", req_yumi_o, 4'b0100);
        tick(); req_v_i = '0; tick(); tick();
        req_v_i = 4'b0010; li_v_i = 1'b1; req_confirm_i = 4'b0100; reset_n_i = 1'b0; #1;
        chk("rs_outputs_zero", all_outs(), 0);
        tick();
        reset_n_i = 1'b1; li_v_i = 1'b0; req_confirm_i = '0; #1;
        chk("rs_regrant", req_yumi_o, 4'b0010);
        tick(); req_v_i = '0; #1;
        chk("rs_start", {start_discovery_o, striding_pc_o}, {1'b1, pc_of(1)});
        reset_n_i = 1'b0; tick(); reset_n_i = 1'b1; #1;
        chk("rs_idle", busy_o, 0);

        // Randomised transactions against a transaction-level model.
        rr_m = 0;
        for (int t = 0; t < 40; t++) begin
            mask = NR'($urandom_range(1, 15));
            own = -1;
            for (int k = 0; k < NR; k++) begin
                if (own < 0 && mask[(rr_m + k) % NR]) own = (rr_m + k) % NR;
            end
            rr_m     = (own + 1) % NR;
            oh       = NR'(1) << own;
            conf_at  = $urandom_range(0, 20);
            to       = (conf_at > TO - 1);
            li_at    = conf_at + $urandom_range(1, 4);
            end_cyc  = to ? TO - 1 : li_at;
            it       = IW'($urandom);

            req_v_i = mask; #1;
            chk("rnd_yumi", req_yumi_o, oh);
            tick(); req_v_i = NR'($urandom); #1;
            chk("rnd_start", {start_discovery_o, striding_pc_o, req_yumi_o}, {1'b1, pc_of(own), 4'b0000});
            tick();
            for (int c = 0; c <= end_cyc; c++) begin
                req_confirm_i = (NR'($urandom) & ~oh) | ((c >= conf_at) ? oh : '0);
                li_v_i        = (c >= li_at) ? 1'b1 : ((c <= conf_at) ? 1'($urandom) : 1'b0);
                li_iters_i    = (c >= li_at) ? it : IW'($urandom);
                resp_ready_i  = 1'($urandom);
                #1;
                chk("rnd_confirm", confirm_discovery_o, (!to && c == conf_at));
                chk("rnd_li_yumi", li_yumi_o, (!to && c == li_at));
                chk("rnd_no_early_resp", {resp_v_o, req_yumi_o}, 0);
                tick();
            end
            req_confirm_i = '0; li_v_i = 1'b0; resp_ready_i = 1'b0; req_v_i = NR'($urandom); #1;
            chk("rnd_resp", {resp_v_o, resp_timeout_o, resp_iters_o, 6'(resp_id_o), req_yumi_o},
                {1'b1, to, (to ? 8'd0 : it), 6'(own), 4'b0000});
            rdy_wait = $urandom_range(0, 3);
            for (int k = 0; k < rdy_wait; k++) begin
                tick();
                chk("rnd_resp_held", {resp_v_o, resp_iters_o, 6'(resp_id_o)},
                    {1'b1, (to ? 8'd0 : it), 6'(own)});
            end
            resp_ready_i = 1'b1; tick(); resp_ready_i = 1'b0; req_v_i = '0; #1;
            chk("rnd_idle", busy_o, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
